// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: time-multiplexed hex display driver for NDIG seven-segment digits.
// A prescaler paces the digit scan. LOAD captures a new value into a shadow
// register, and that value reaches the display register only at a frame
// boundary, so a frame never shows a mix of old and new digits.
module hex_scan_ctrl #(
  parameter int unsigned NDIG = 8,
  parameter int unsigned DIV  = 100000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [4*NDIG-1:0] VAL,
  input  logic [NDIG-1:0]   DP,
  input  logic              LOAD,
  input  logic              BLANK_LZ,
  input  logic              EN,
  output logic [7:0]        SSEG_CA,
  output logic [NDIG-1:0]   SSEG_AN,
  output logic              FRAME,
  output logic              PEND
);

  localparam int unsigned VAL_W = 4 * NDIG;
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  // Segment pattern for one hex nibble, active low, {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // State registers
  logic [PRE_W-1:0] presc_q,    presc_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [VAL_W-1:0] shad_val_q, shad_val_d;
  logic [NDIG-1:0]  shad_dp_q,  shad_dp_d;
  logic [VAL_W-1:0] disp_val_q, disp_val_d;
  logic [NDIG-1:0]  disp_dp_q,  disp_dp_d;
  logic             pend_q,     pend_d;
  logic             frame_q,    frame_d;
  logic [NDIG-1:0]  an_q,       an_d;
  logic [7:0]       ca_q,       ca_d;

  // Scan timing decode
  logic tick_c;
  logic boundary_c;

  // Current-digit decode taken from the display register
  logic [VAL_W-1:0] disp_sh_c;
  logic [3:0]       nib_c;
  logic             dp_c;
  logic             blank_c;

  // Prescaler wrap and frame boundary detection
  always_comb begin
    tick_c     = (presc_q == PRE_LAST);
    boundary_c = tick_c && (idx_q == IDX_LAST);
  end

  // Prescaler and digit index advance
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (tick_c) begin
      presc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Shadow capture, pending flag and frame-aligned commit to the display register
  always_comb begin
    shad_val_d = shad_val_q;
    shad_dp_d  = shad_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pend_d     = pend_q;
    frame_d    = boundary_c;
    if (LOAD) begin
      shad_val_d = VAL;
      shad_dp_d  = DP;
    end
    if (boundary_c) begin
      // A LOAD landing on the boundary bypasses the shadow and shows at once
      if (LOAD) begin
        disp_val_d = VAL;
        disp_dp_d  = DP;
      end else if (pend_q) begin
        disp_val_d = shad_val_q;
        disp_dp_d  = shad_dp_q;
      end
      pend_d = 1'b0;
    end else if (LOAD) begin
      pend_d = 1'b1;
    end
  end

  // Select the active digit's nibble, decimal point and leading-zero blanking
  always_comb begin
    disp_sh_c = disp_val_q >> {idx_q, 2'b00};
    nib_c     = 4'(disp_sh_c);
    dp_c      = 1'(disp_dp_q >> idx_q);
    // Blank when this nibble and everything above it is zero; digit 0 always shows
    blank_c   = BLANK_LZ && (idx_q != '0) && (disp_sh_c == '0);
  end

  // Anode and cathode patterns for the next cycle
  always_comb begin
    an_d = '1;
    ca_d = 8'hFF;
    if (EN) begin
      an_d = ~(NDIG'(1) << idx_q);
    end
    ca_d[7]   = ~dp_c;
    ca_d[6:0] = blank_c ? 7'h7F : seg7(nib_c);
  end

  // All state on the rising edge, asynchronous active-high reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q    <= '0;
      idx_q      <= '0;
      shad_val_q <= '0;
      shad_dp_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pend_q     <= 1'b0;
      frame_q    <= 1'b0;
      an_q       <= '1;
      ca_q       <= 8'hFF;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      shad_val_q <= shad_val_d;
      shad_dp_q  <= shad_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pend_q     <= pend_d;
      frame_q    <= frame_d;
      an_q       <= an_d;
      ca_q       <= ca_d;
    end
  end

  assign SSEG_AN = an_q;
  assign SSEG_CA = ca_q;
  assign FRAME   = frame_q;
  assign PEND    = pend_q;

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 Parameter NDIG, default 8, number of multiplexed digits (2..8).
REQ-002 Parameter DIV, default 100000, CLK cycles per digit slot (>=2).
REQ-003 One clock; reset is asynchronous and active-high; ports CLK and RST.
REQ-004 CLK  in  1  system clock, all state on rising edge.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 VAL  in  4*NDIG  hex nibbles; nibble i (VAL[4i+3:4i]) drives digit i, digit 0 rightmost.
REQ-007 DP  in  NDIG  decimal point request per digit, 1 = lit.
REQ-008 LOAD  in  1  single-cycle strobe; captures VAL/DP into shadow register.
REQ-009 BLANK_LZ  in  1  1 = suppress leading zeros.
REQ-010 EN  in  1  0 = all anodes off.
REQ-011 SSEG_CA  out  8  cathodes, active low, bit order {DP,g,f,e,d,c,b,a}.
REQ-012 SSEG_AN  out  NDIG  anodes, active low, one-hot-low when EN=1.
REQ-013 FRAME  out  1  one-cycle pulse at each frame boundary.
REQ-014 PEND  out  1  shadow holds data not yet committed to display register.

Function
REQ-015 Prescaler counts 0..DIV-1 and wraps; TICK asserted on the cycle the count equals DIV-1.
REQ-016 On TICK, digit index advances idx -> idx+1, NDIG-1 -> 0 (frame boundary).
REQ-017 FRAME is registered, high exactly one cycle following each frame-boundary TICK.
REQ-018 LOAD writes shadow <= {VAL,DP} and sets PEND=1; repeated LOADs before commit overwrite, last wins.
REQ-019 At frame-boundary TICK, if PEND=1, display <= shadow and PEND clears; display never changes mid-frame.
REQ-020 LOAD on the same cycle as a frame-boundary TICK: VAL/DP commit directly to display, shadow also updated, PEND ends 0.
REQ-021 Outputs registered: SSEG_AN/SSEG_CA reflect idx and display register with one cycle latency.
REQ-022 SSEG_AN = EN ? ~(1<<idx) : all ones; EN change visible next cycle, scan continues while EN=0.
REQ-023 Hex encoding bits[6:0] (as 8-bit, DP off): 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,8 80,9 90,A 88,b 83,C C6,d A1,E 86,F 8E.
REQ-024 DP bit (SSEG_CA[7]) = ~DP[idx] of display register, independent of blanking.
REQ-025 BLANK_LZ=1: digit i blanked (bits[6:0]=7F) iff nibble i and all higher nibbles are zero and i>0; digit 0 never blanked.
REQ-026 Blanking evaluated from display register, not shadow or live VAL.
REQ-027 Worst-case LOAD-to-visible latency: NDIG*DIV+1 cycles.

Reset
REQ-028 RST=1 asynchronously forces: prescaler 0, idx 0, shadow 0, display 0, PEND 0, FRAME 0, SSEG_AN all ones, SSEG_CA FF.
REQ-029 RST asserted mid-frame or with PEND=1 discards pending data; no commit on release.
REQ-030 First rising edge after release with EN=1 drives SSEG_AN = ~1 and SSEG_CA = C0.

Verification (NDIG=4, DIV=4)
REQ-031 Reset then EN=1, LOAD VAL=16'h12AF, DP=0 -> after commit, scan over 16 cycles shows AN E/D/B/7 with CA 8E/88/A4/F9.
REQ-032 LOAD 16'h0000 then 16'h00F0 within one frame -> only 00F0 ever displayed; PEND 1 until boundary, then 0.
REQ-033 BLANK_LZ=1, VAL=16'h0050, DP=4'b0100 -> digits 3 CA=FF, digit 2 CA=7F, digit 1 CA=92, digit 0 CA=C0.
REQ-034 LOAD coincident with boundary TICK -> new value on digit 0 next cycle, PEND stays 0, FRAME pulses once.
REQ-035 EN=0 mid-frame -> SSEG_AN all ones next cycle; FRAME still pulses every 16 cycles; EN=1 resumes at current idx.
REQ-036 RST pulse mid-frame with PEND=1 -> outputs FF/all-ones immediately, PEND 0, display 0 after release.
